// File: rtl/coin_acceptor.sv
// Coin acceptor front end: synchronises and debounces two coin-slot sensors, then
// classifies each insertion into a single-cycle coin code, a reject pulse or a jam.
module coin_acceptor #(
    parameter int unsigned DEB_CYCLES = 4,
    parameter int unsigned MAX_PULSE  = 32,
    parameter int unsigned MIN_GAP    = 2
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       sens_a,
    input  logic       sens_b,
    input  logic       vend_busy,
    output logic [1:0] coin,
    output logic       reject,
    output logic       jam
);

    localparam int unsigned DebW = $clog2(DEB_CYCLES + 1);
    localparam int unsigned LenW = $clog2(MAX_PULSE + 1);
    localparam int unsigned GapW = (MIN_GAP > 1) ? $clog2(MIN_GAP + 1) : 1;

    typedef enum logic [2:0] {StIdle, StHold, StEmit, StRej, StJam, StGap} state_t;

    // Bit 0 is sensor a, bit 1 is sensor b throughout.
    logic [1:0]            sync1_q, sync2_q;
    logic [1:0]            deb_q, deb_d, deb_prev_q;
    logic [1:0][DebW-1:0]  deb_cnt_q, deb_cnt_d;
    logic [1:0]            rise;

    state_t                state_q, state_d;
    logic [1:0]            type_q, type_d;
    logic                  bad_q, bad_d;
    logic [LenW-1:0]       len_q, len_d;
    logic [GapW-1:0]       gap_q, gap_d;
    logic [1:0]            warm_q, warm_d;
    logic                  armed_q, armed_d;
    logic [1:0]            coin_q, coin_d;
    logic                  reject_q, reject_d;
    logic                  jam_q, jam_d;
    logic                  latched_lvl, other_lvl;

    assign rise = deb_q & ~deb_prev_q;

    // Debounce: a level change must persist DEB_CYCLES synced samples before it is taken.
    always_comb begin
        deb_d     = deb_q;
        deb_cnt_d = '0;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != deb_q[i]) begin
                if (deb_cnt_q[i] + DebW'(1) == DebW'(DEB_CYCLES)) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + DebW'(1);
                end
            end
        end
    end

    // After reset, refuse new coins until both sensors are seen low, so a coin
    // interrupted by reset is never emitted when its sensor later settles.
    always_comb begin
        warm_d  = (warm_q == 2'd2) ? warm_q : warm_q + 2'd1;
        armed_d = armed_q | ((warm_q == 2'd2) && (sync2_q == 2'b00) && (deb_q == 2'b00));
    end

    // Insertion FSM next state plus registered output decode.
    always_comb begin
        state_d     = state_q;
        type_d      = type_q;
        bad_d       = bad_q;
        len_d       = len_q;
        gap_d       = gap_q;
        latched_lvl = (type_q == 2'd2) ? deb_q[1] : deb_q[0];
        other_lvl   = (type_q == 2'd2) ? deb_q[0] : deb_q[1];
        unique case (state_q)
            StIdle: begin
                if (armed_q && (rise != 2'b00)) begin
                    state_d = StHold;
                    len_d   = '0;
                    // Simultaneous rises are tracked on sensor a but always rejected.
                    type_d  = (rise == 2'b10) ? 2'd2 : 2'd1;
                    bad_d   = (rise == 2'b11);
                end
            end
            StHold: begin
                len_d = len_q + LenW'(1);
                if (other_lvl) begin
                    bad_d = 1'b1;
                end
                if (!latched_lvl) begin
                    state_d = (!(bad_q || other_lvl) && !vend_busy) ? StEmit : StRej;
                end else if (len_q + LenW'(1) == LenW'(MAX_PULSE)) begin
                    state_d = StJam;
                end
            end
            StEmit, StRej: begin
                state_d = StGap;
                gap_d   = '0;
            end
            StJam: begin
                if (deb_q == 2'b00) begin
                    state_d = StRej;
                end
            end
            StGap: begin
                gap_d = gap_q + GapW'(1);
                if (gap_q + GapW'(1) == GapW'(MIN_GAP)) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        coin_d   = (state_d == StEmit) ? type_q : 2'd0;
        reject_d = (state_d == StRej);
        jam_d    = (state_d == StJam);
    end

    // All state: synchroniser, debounce, FSM and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            deb_cnt_q  <= '0;
            state_q    <= StIdle;
            type_q     <= '0;
            bad_q      <= 1'b0;
            len_q      <= '0;
            gap_q      <= '0;
            warm_q     <= '0;
            armed_q    <= 1'b0;
            coin_q     <= '0;
            reject_q   <= 1'b0;
            jam_q      <= 1'b0;
        end else begin
            sync1_q    <= {sens_b, sens_a};
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            deb_cnt_q  <= deb_cnt_d;
            state_q    <= state_d;
            type_q     <= type_d;
            bad_q      <= bad_d;
            len_q      <= len_d;
            gap_q      <= gap_d;
            warm_q     <= warm_d;
            armed_q    <= armed_d;
            coin_q     <= coin_d;
            reject_q   <= reject_d;
            jam_q      <= jam_d;
        end
    end

    assign coin   = coin_q;
    assign reject = reject_q;
    assign jam    = jam_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor. Inputs change on the falling edge; outputs are
// checked on the falling edge. Loop index k counts rising edges since the scenario began,
// so an input set before edge k is first sampled at edge k.
module tb_coin_acceptor;

    logic       clk = 1'b0;
    logic       rstn;
    logic       sens_a;
    logic       sens_b;
    logic       vend_busy;
    logic [1:0] coin;
    logic       reject;
    logic       jam;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    coin_acceptor #(
        .DEB_CYCLES(4),
        .MAX_PULSE (32),
        .MIN_GAP   (2)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .sens_a   (sens_a),
        .sens_b   (sens_b),
        .vend_busy(vend_busy),
        .coin     (coin),
        .reject   (reject),
        .jam      (jam)
    );

    task automatic settle(input int n);
        sens_a    = 1'b0;
        sens_b    = 1'b0;
        vend_busy = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rstn      = 1'b1;
        sens_a    = 1'b0;
        sens_b    = 1'b0;
        vend_busy = 1'b0;
        #1 rstn = 1'b0;
        #1;
        total++; if (coin !== 2'd0) begin bad++; $display("FAIL reset_coin got=%0d want=0", coin); end
        total++; if (reject !== 1'b0) begin bad++; $display("FAIL reset_reject got=%b want=0", reject); end
        total++; if (jam !== 1'b0) begin bad++; $display("FAIL reset_jam got=%b want=0", jam); end
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        settle(6);
    endtask

    // Sensor a high for samples 1..10; coin=1 appears after edge 17 only.
    task automatic test_single_a();
        logic [1:0] exp_coin;
        for (int k = 1; k <= 30; k++) begin
            sens_a = (k <= 10) ? 1'b1 : 1'b0;
            @(negedge clk);
            exp_coin = (k == 17) ? 2'd1 : 2'd0;
            total++; if (coin !== exp_coin) begin bad++; $display("FAIL single_a_coin k=%0d got=%0d want=%0d", k, coin, exp_coin); end
            total++; if (reject !== 1'b0 || jam !== 1'b0) begin bad++; $display("FAIL single_a_flags k=%0d got rej=%b jam=%b want 0 0", k, reject, jam); end
        end
        settle(5);
    endtask

    // Coin a then coin b with 8 low cycles between: pulses 1 at edge 17, 2 at edge 35.
    task automatic test_back_to_back();
        logic [1:0] exp_coin;
        for (int k = 1; k <= 50; k++) begin
            sens_a = (k <= 10) ? 1'b1 : 1'b0;
            sens_b = (k >= 19 && k <= 28) ? 1'b1 : 1'b0;
            @(negedge clk);
            exp_coin = (k == 17) ? 2'd1 : ((k == 35) ? 2'd2 : 2'd0);
            total++; if (coin !== exp_coin) begin bad++; $display("FAIL b2b_coin k=%0d got=%0d want=%0d", k, coin, exp_coin); end
            total++; if (reject !== 1'b0) begin bad++; $display("FAIL b2b_reject k=%0d got=%b want=0", k, reject); end
        end
        settle(5);
    endtask

    // Short glitch on a and per-cycle bounce on b never debounce into an event.
    task automatic test_glitch();
        for (int k = 1; k <= 35; k++) begin
            sens_a = (k <= 2) ? 1'b1 : 1'b0;
            sens_b = (k <= 20 && k[0]) ? 1'b1 : 1'b0;
            @(negedge clk);
            total++; if (coin !== 2'd0 || reject !== 1'b0) begin bad++; $display("FAIL glitch k=%0d got coin=%0d rej=%b want 0 0", k, coin, reject); end
        end
        settle(5);
    endtask

    // Sensor b debounces high while coin a is held: rejected at edge 17.
    task automatic test_double_sensor();
        logic exp_rej;
        for (int k = 1; k <= 30; k++) begin
            sens_a = (k <= 10) ? 1'b1 : 1'b0;
            sens_b = (k >= 3 && k <= 6) ? 1'b1 : 1'b0;
            @(negedge clk);
            exp_rej = (k == 17) ? 1'b1 : 1'b0;
            total++; if (reject !== exp_rej) begin bad++; $display("FAIL double_reject k=%0d got=%b want=%b", k, reject, exp_rej); end
            total++; if (coin !== 2'd0) begin bad++; $display("FAIL double_coin k=%0d got=%0d want=0", k, coin); end
        end
        settle(5);
    endtask

    // Busy at release rejects; busy only while held has no effect.
    task automatic test_busy();
        logic exp_rej;
        logic [1:0] exp_coin;
        for (int k = 1; k <= 30; k++) begin
            sens_a    = (k <= 10) ? 1'b1 : 1'b0;
            vend_busy = 1'b1;
            @(negedge clk);
            exp_rej = (k == 17) ? 1'b1 : 1'b0;
            total++; if (reject !== exp_rej) begin bad++; $display("FAIL busy_reject k=%0d got=%b want=%b", k, reject, exp_rej); end
            total++; if (coin !== 2'd0) begin bad++; $display("FAIL busy_coin k=%0d got=%0d want=0", k, coin); end
        end
        settle(5);
        for (int k = 1; k <= 30; k++) begin
            sens_a    = (k <= 10) ? 1'b1 : 1'b0;
            vend_busy = (k <= 10) ? 1'b1 : 1'b0;
            @(negedge clk);
            exp_coin = (k == 17) ? 2'd1 : 2'd0;
            total++; if (coin !== exp_coin) begin bad++; $display("FAIL busy_early_coin k=%0d got=%0d want=%0d", k, coin, exp_coin); end
            total++; if (reject !== 1'b0) begin bad++; $display("FAIL busy_early_reject k=%0d got=%b want=0", k, reject); end
        end
        settle(5);
    endtask

    // Sensor a held 50 samples: jam rises ~32 debounced-high cycles in, holds, then
    // release yields one reject at edge 57 with jam dropping on that same edge.
    task automatic test_jam();
        int   first_jam = 0;
        logic exp_rej;
        for (int k = 1; k <= 70; k++) begin
            sens_a = (k <= 50) ? 1'b1 : 1'b0;
            @(negedge clk);
            if (jam === 1'b1 && first_jam == 0) first_jam = k;
            exp_rej = (k == 57) ? 1'b1 : 1'b0;
            total++; if (coin !== 2'd0) begin bad++; $display("FAIL jam_coin k=%0d got=%0d want=0", k, coin); end
            total++; if (reject !== exp_rej) begin bad++; $display("FAIL jam_reject k=%0d got=%b want=%b", k, reject, exp_rej); end
            if (k <= 30 || k >= 57) begin
                total++; if (jam !== 1'b0) begin bad++; $display("FAIL jam_low k=%0d got=%b want=0", k, jam); end
            end else if (k >= 41) begin
                total++; if (jam !== 1'b1) begin bad++; $display("FAIL jam_high k=%0d got=%b want=1", k, jam); end
            end
        end
        total++;
        if (first_jam < 37 || first_jam > 40) begin
            bad++; $display("FAIL jam_onset got=%0d want 37..40", first_jam);
        end
        settle(5);
    endtask

    // Reset mid-HOLD drops the coin for good; reset during jam clears jam at once.
    task automatic test_reset_mid_hold();
        logic [1:0] exp_coin;
        for (int k = 1; k <= 10; k++) begin
            sens_a = 1'b1;
            @(negedge clk);
        end
        rstn = 1'b0;
        #1;
        total++; if (coin !== 2'd0 || reject !== 1'b0 || jam !== 1'b0) begin bad++; $display("FAIL rst_hold_outs got coin=%0d rej=%b jam=%b want 0 0 0", coin, reject, jam); end
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            sens_a = (k <= 10) ? 1'b1 : 1'b0;
            @(negedge clk);
            total++; if (coin !== 2'd0 || reject !== 1'b0) begin bad++; $display("FAIL rst_hold_after k=%0d got coin=%0d rej=%b want 0 0", k, coin, reject); end
        end
        for (int k = 1; k <= 42; k++) begin
            sens_a = 1'b1;
            @(negedge clk);
        end
        total++; if (jam !== 1'b1) begin bad++; $display("FAIL rst_jam_pre got=%b want=1", jam); end
        rstn = 1'b0;
        #1;
        total++; if (jam !== 1'b0 || reject !== 1'b0 || coin !== 2'd0) begin bad++; $display("FAIL rst_jam_clear got jam=%b rej=%b coin=%0d want 0 0 0", jam, reject, coin); end
        @(negedge clk);
        rstn   = 1'b1;
        sens_a = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            total++; if (coin !== 2'd0 || reject !== 1'b0 || jam !== 1'b0) begin bad++; $display("FAIL rst_jam_after k=%0d got coin=%0d rej=%b jam=%b want 0 0 0", k, coin, reject, jam); end
        end
        for (int k = 1; k <= 30; k++) begin
            sens_a = (k <= 10) ? 1'b1 : 1'b0;
            @(negedge clk);
            exp_coin = (k == 17) ? 2'd1 : 2'd0;
            total++; if (coin !== exp_coin) begin bad++; $display("FAIL rst_next_coin k=%0d got=%0d want=%0d", k, coin, exp_coin); end
        end
        settle(5);
    endtask

    initial begin
        test_reset();
        test_single_a();
        test_back_to_back();
        test_glitch();
        test_double_sensor();
        test_busy();
        test_jam();
        test_reset_mid_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
